// File: rtl/wb_select_stage.sv
// Writeback stage: selects one of NSRC results or an extracted data-memory load
// and drives the register-file write port, waiting for late load data.
module wb_select_stage #(
    parameter int DATA_W   = 32,
    parameter int NSRC     = 3,
    parameter int SEL_W    = 2,
    parameter int DMEM_IDX = 1,
    parameter int ADDR_W   = 5,
    parameter int OFF_W    = $clog2(DATA_W / 8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [NSRC*DATA_W-1:0] in_src,
    input  logic                   in_wen,
    input  logic [ADDR_W-1:0]      in_waddr,
    input  logic [2:0]             in_load_mode,
    input  logic [OFF_W-1:0]       in_byte_off,
    input  logic                   dmem_rvalid,
    input  logic [DATA_W-1:0]      dmem_rdata,
    input  logic                   flush,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] DMEM_SEL = DMEM_IDX[SEL_W-1:0];
    localparam logic [SEL_W:0]   NSRC_LIM = NSRC[SEL_W:0];

    state_t              state_r;
    logic [ADDR_W-1:0]   wait_waddr_r;
    logic                wait_wen_r;
    logic [2:0]          wait_mode_r;
    logic [OFF_W-1:0]    wait_off_r;

    logic                accept_s;
    logic                is_load_s;
    logic                sel_ok_s;
    logic [DATA_W-1:0]   src_mux_s;

    // Pull the addressed byte or halfword out of an aligned word and extend it.
    function automatic logic [DATA_W-1:0] extract(
        input logic [DATA_W-1:0] rdata,
        input logic [2:0]        mode,
        input logic [OFF_W-1:0]  off
    );
        logic [OFF_W-1:0]  hoff;
        logic [DATA_W-1:0] bsh;
        logic [DATA_W-1:0] hsh;
        logic [DATA_W-1:0] res;
        hoff    = off;
        hoff[0] = 1'b0;
        bsh     = rdata >> {off, 3'b000};
        hsh     = rdata >> {hoff, 3'b000};
        case (mode)
            3'b001:  res = {{(DATA_W-8){bsh[7]}}, bsh[7:0]};
            3'b010:  res = {{(DATA_W-8){1'b0}}, bsh[7:0]};
            3'b011:  res = {{(DATA_W-16){hsh[15]}}, hsh[15:0]};
            3'b100:  res = {{(DATA_W-16){1'b0}}, hsh[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    assign in_ready  = (state_r == IDLE) && !flush;
    assign accept_s  = in_valid && in_ready;
    assign is_load_s = (in_sel == DMEM_SEL);
    assign sel_ok_s  = ({1'b0, in_sel} < NSRC_LIM);

    // Source mux over the legal slots; an out-of-range select yields zero but is never written.
    always_comb begin
        src_mux_s = '0;
        for (int k = 0; k < NSRC; k++) begin
            src_mux_s = (in_sel == SEL_W'(k)) ? in_src[k*DATA_W +: DATA_W] : src_mux_s;
        end
    end

    // Writeback FSM: immediate writes from IDLE, deferred load completion from WAIT_MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            wait_waddr_r <= '0;
            wait_wen_r   <= 1'b0;
            wait_mode_r  <= 3'b000;
            wait_off_r   <= '0;
        end else begin
            rf_we <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (is_load_s) begin
                            if (dmem_rvalid) begin
                                rf_wdata <= extract(dmem_rdata, in_load_mode, in_byte_off);
                                rf_waddr <= in_waddr;
                                rf_we    <= in_wen && (in_waddr != '0);
                            end else begin
                                wait_waddr_r <= in_waddr;
                                wait_wen_r   <= in_wen;
                                wait_mode_r  <= in_load_mode;
                                wait_off_r   <= in_byte_off;
                                state_r      <= WAIT_MEM;
                            end
                        end else if (sel_ok_s) begin
                            rf_wdata <= src_mux_s;
                            rf_waddr <= in_waddr;
                            rf_we    <= in_wen && (in_waddr != '0);
                        end
                    end
                end
                WAIT_MEM: begin
                    // Flush wins over a same-cycle rvalid and drops the pending load.
                    if (flush) begin
                        state_r      <= IDLE;
                        wait_waddr_r <= '0;
                        wait_wen_r   <= 1'b0;
                        wait_mode_r  <= 3'b000;
                        wait_off_r   <= '0;
                    end else if (dmem_rvalid) begin
                        rf_wdata <= extract(dmem_rdata, wait_mode_r, wait_off_r);
                        rf_waddr <= wait_waddr_r;
                        rf_we    <= wait_wen_r && (wait_waddr_r != '0);
                        state_r  <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Registered, parametrised writeback stage for the CPU datapath, sitting between the MEM stage and the register file. It generalises the old 3-way writeback select to `NSRC` sources of `DATA_W` bits. It adds sub-word load extraction with sign or zero extension, and it waits for variable-latency data-memory reads using a two-state FSM with upstream backpressure. It drives the register-file write port directly, and suppresses writes to r0 and to illegal selects.

## Interface
Parameters:
- `DATA_W`, default 32: datapath width. Must be a power of two and at least 16.
- `NSRC`, default 3: number of writeback sources, 2..16.
- `SEL_W`, default 2: select width. Must satisfy 2^SEL_W >= NSRC.
- `DMEM_IDX`, default 1: the select value that means "take the data-memory read". The `in_src` slot at this index is ignored.
- `ADDR_W`, default 5: register-file address width.
- `OFF_W`: byte-offset width, fixed at log2(DATA_W/8).

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset. **Asynchronous, active-high.**
- `in_valid`, in, 1: an instruction is presented for writeback.
- `in_ready`, out, 1: equals (state == IDLE) && !flush. Combinational.
- `in_sel`, in, SEL_W: source select.
- `in_src`, in, NSRC*DATA_W: flattened sources. Slot k is `in_src[k*DATA_W +: DATA_W]`.
- `in_wen`, in, 1: the instruction writes the register file.
- `in_waddr`, in, ADDR_W: destination register.
- `in_load_mode`, in, 3: 000 full word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned. Values 101..111 are treated as 000.
- `in_byte_off`, in, OFF_W: byte offset of the load address.
- `dmem_rvalid`, in, 1: `dmem_rdata` is valid this cycle.
- `dmem_rdata`, in, DATA_W: raw aligned data-memory word.
- `flush`, in, 1: discard any pending or presented instruction.
- `rf_we`, out, 1: register-file write enable (registered).
- `rf_waddr`, out, ADDR_W: registered write address.
- `rf_wdata`, out, DATA_W: registered write data.

## Operation
- FSM states:
  - IDLE: accepts an instruction.
  - WAIT_MEM: a load is outstanding.
- Accept: an instruction is accepted on a rising edge where in_valid && in_ready.
- Non-load accept (in_sel != DMEM_IDX):
  - Registers rf_wdata = slot in_sel.
  - Registers rf_waddr = in_waddr.
  - Registers rf_we = in_wen && (in_waddr != 0) && (in_sel < NSRC).
  - State stays IDLE.
- Load accept with dmem_rvalid high in the same cycle:
  - Same as a non-load accept, but rf_wdata = extract(dmem_rdata) and the select-range check is not applied.
  - State stays IDLE.
- Load accept with dmem_rvalid low:
  - Latch in_waddr, in_wen, in_load_mode and in_byte_off internally.
  - rf_we = 0. Go to WAIT_MEM.
- WAIT_MEM with dmem_rvalid and no flush:
  - Register extract(dmem_rdata) and the latched address.
  - rf_we = latched wen && (addr != 0).
  - Return to IDLE.
- Flush:
  - In WAIT_MEM: return to IDLE, rf_we = 0, discard the latched load.
  - With in_valid in IDLE: nothing is accepted (in_ready is 0).
  - Flush always takes priority over dmem_rvalid.
- Illegal select (in_sel >= NSRC, not DMEM_IDX): rf_we = 0, and rf_wdata/rf_waddr keep their previous values.
- Writes to address 0: rf_we = 0, but rf_wdata and rf_waddr still update.
- Cycles with no accept and no completion: rf_we = 0, and rf_wdata/rf_waddr hold.
- extract() rules, with b = byte lane at in_byte_off:
  - Full word: rdata unchanged.
  - Byte: lane b, sign- or zero-extended to DATA_W.
  - Half: 16-bit lane at byte index (off & ~1). Bit 0 of the offset is ignored.

## Timing
- Reset values: rf_we = 0, rf_waddr = 0, rf_wdata = 0, state = IDLE, all internal latches = 0.
- Reset mid-WAIT_MEM: the pending load is dropped and no write occurs.
- Latency: the write appears one cycle after accept (non-load, or load with same-cycle rvalid). A waiting load writes one cycle after the dmem_rvalid edge.
- Throughput: one instruction per cycle while no load is waiting.
- rf_we pulses for exactly one cycle per completed instruction.
- In WAIT_MEM, in_ready = 0. If in_valid and dmem_rvalid are high together, only the load completes; the new instruction is accepted no earlier than the next cycle, once the stage is back in IDLE.
- dmem_rvalid in IDLE without a load accept is ignored.

## Test plan
- Reset, then in_sel=0, slot0=0x1234_5678, waddr=5, wen=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678. The following idle cycle -> rf_we=0.
- Load, byte signed, off=2, dmem_rdata=0x0080_FF11, rvalid delayed 3 cycles -> in_ready=0 for 3 cycles, then rf_wdata=0xFFFF_FF80 with rf_we=1 for one cycle.
- Half unsigned, off=3, rdata=0xABCD_1234, same-cycle rvalid -> rf_wdata=0x0000_ABCD. Byte unsigned, off=0, same rdata -> 0x0000_0034.
- Flush asserted while in WAIT_MEM, rvalid on the same edge -> rf_we stays 0, state IDLE, in_ready=1 once flush drops.
- waddr=0 with wen=1 -> rf_we=0. in_sel=3 with NSRC=3 -> rf_we=0 and rf_wdata unchanged.
- Back-to-back ALU instructions to r1..r4 on 4 consecutive cycles -> 4 consecutive rf_we pulses with matching data. Asserting rst asynchronously mid-stream -> all outputs go to 0 immediately.
